boa_stage_ex: RTL
=================

Name: boa_stage_ex

Overview:
Boa³² EX pipeline stage. Sits between ID and MEM. Registers the ID/EX barrier and computes the ALU result, load/store address, link value and store data, then presents them to MEM on the EX/MEM interface. Contains an iterative 32-step multiply/divide unit (MDU) that stalls the front of the pipeline while it runs.

Parameters:
none (the MDU is selected by macro, see Optional Feature)

Ports:
clk  in  1  CPU clock
rst  in  1  reset; asynchronous, active-high
clear  in  1  invalidate the held instruction, abort the MDU, suppress traps
d_valid  in  1  ID/EX: instruction valid
d_pc  in  31  ID/EX: instruction PC [31:1]
d_insn  in  32  ID/EX: instruction word
d_use_rd  in  1  ID/EX: instruction writes RD
d_rs1_val  in  32  ID/EX: forwarded RS1 value
d_rs2_val  in  32  ID/EX: forwarded RS2 value
d_trap  in  1  ID/EX: upstream trap
d_cause  in  4  ID/EX: upstream trap cause
q_valid  out  1  EX/MEM: result valid
q_pc  out  31  EX/MEM: PC
q_insn  out  32  EX/MEM: instruction word
q_use_rd  out  1  EX/MEM: writes RD
q_rs1_val  out  32  EX/MEM: ALU result or memory address
q_rs2_val  out  32  EX/MEM: store data (RS2 passthrough)
q_trap  out  1  EX/MEM: trap raised
q_cause  out  4  EX/MEM: trap cause
fw_stall_ex  in  1  hold the EX barrier register (downstream stall)
fw_stall_out  out  1  EX is busy; upstream stages must stall

Behaviour:
- Barrier register r_* (valid, pc, insn, use_rd, rs1, rs2, trap, cause):
  - Async rst clears r_valid and r_trap to 0. All other fields reset to 0.
  - Loads from d_* on the clock edge when fw_stall_ex=0 and fw_stall_out=0. Otherwise it holds.
- Immediates decode per RV32I I/S/U/J formats from r_insn.
- Result into q_rs1_val:
  - OP / OP-IMM: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is the low 5 bits.
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL / JALR: pc+4.
  - LOAD / STORE: rs1+imm.
  - Any other opcode: rs1 passthrough.
- All arithmetic is mod 2^32.
- Non-MDU result is combinational from r_*, so latency is 1 cycle (capture edge to q_*).
- MDU FSM states IDLE, BUSY, DONE:
  - IDLE→BUSY on the cycle a valid, non-trapped OP with funct7=0000001 is held. fw_stall_out=1 combinationally from that cycle. Operands are latched and a 5-bit counter is set to 31.
  - BUSY: one shift-add (MUL*) or restoring-divide (DIV*/REM*) step per cycle. The counter decrements. At counter=0 the FSM goes to DONE.
  - Signed ops: operands are converted to magnitudes and the sign is fixed up in the final step. MULH/MULHSU/MULHU return the upper 32 bits; MUL returns the lower 32.
  - DONE: q_rs1_val=MDU result, q_valid=1, fw_stall_out=0. The FSM goes to IDLE on the next edge with fw_stall_ex=0. While fw_stall_ex=1 it remains in DONE and holds the result.
  - An MDU op captured at edge N gives fw_stall_out=1 for cycles N..N+32 and q_valid=1 at cycle N+33.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. No trap.
- Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0.
- q_valid = r_valid && !clear && (non-MDU op || state==DONE).
- q_trap = r_trap && !clear. q_cause = r_cause. EX raises no trap of its own except the case in Optional Feature.
- clear: the FSM returns to IDLE on the next edge, r_valid is cleared, and fw_stall_out drops the next cycle.
- rst mid-MDU: the FSM goes to IDLE immediately (asynchronously) and all q_* deassert.
- Trapped (r_trap) or invalid instructions never start the MDU.

Optional Feature:
- Macro: BOA_EX_MDU_EN.
- Defined: MDU present as described above.
- Undefined:
  - No MDU logic is built and fw_stall_out is tied 0.
  - OP with funct7=0000001 gives q_trap=1, q_cause=2 (illegal instruction), q_valid=0.

Test Plan:
- ADDI rs1=5, imm=-3 → q_rs1_val=0x00000002, q_valid=1 one cycle after capture, fw_stall_out=0.
- SRA rs1=0x80000000, rs2=0x24 → q_rs1_val=0xF8000000 (shift amount 4). SLTU 1<0xFFFFFFFF → 1.
- DIV rs1=7, rs2=-2 → 0xFFFFFFFD. REM on the same operands → 1. fw_stall_out high for 33 cycles, then one q_valid pulse.
- DIVU rs2=0 → 0xFFFFFFFF. REM by 0 with rs1=9 → 9. DIV 0x80000000/-1 → 0x80000000.
- MULH 0x80000000*0x80000000 → 0x40000000. MUL 0xFFFFFFFF*3 → 0xFFFFFFFD.
- clear at BUSY cycle 10 → q_valid never asserts, fw_stall_out=0 the next cycle. Build with BOA_EX_MDU_EN undefined and issue MUL → q_trap=1, q_cause=2.

Source files
------------

// File: rtl/boa_stage_ex.sv
// -----------------------------------------------------------------------------
// boa_stage_ex -- Boa32 EX pipeline stage (between ID and MEM).
//
// Registers the ID/EX barrier and produces the EX/MEM payload: ALU result,
// load/store effective address, link value (pc+4) and store data.
//
// Optional iterative multiply/divide unit, built only when the macro
// BOA_EX_MDU_EN is defined. Without it, an OP with funct7=0000001 is reported
// as an illegal instruction (q_trap=1, q_cause=2) and fw_stall_out is 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           flush: drop held instruction, abort MDU, suppress traps
//   d_*             ID/EX barrier inputs (valid, pc[31:1], insn, use_rd,
//                   rs1/rs2 values, upstream trap + cause)
//   q_*             EX/MEM outputs (q_rs1_val = result or address,
//                   q_rs2_val = store data)
//   fw_stall_ex     downstream stall: hold the barrier register
//   fw_stall_out    EX busy (MDU running): upstream stages must stall
// -----------------------------------------------------------------------------
module boa_stage_ex (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        d_valid,
   input  logic [30:0] d_pc,
   input  logic [31:0] d_insn,
   input  logic        d_use_rd,
   input  logic [31:0] d_rs1_val,
   input  logic [31:0] d_rs2_val,
   input  logic        d_trap,
   input  logic [3:0]  d_cause,
   output logic        q_valid,
   output logic [30:0] q_pc,
   output logic [31:0] q_insn,
   output logic        q_use_rd,
   output logic [31:0] q_rs1_val,
   output logic [31:0] q_rs2_val,
   output logic        q_trap,
   output logic [3:0]  q_cause,
   input  logic        fw_stall_ex,
   output logic        fw_stall_out
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

   // ------------------------------------------------------------------
   // ID/EX barrier
   // ------------------------------------------------------------------
   logic        r_valid;
   logic [30:0] r_pc;
   logic [31:0] r_insn;
   logic        r_use_rd;
   logic [31:0] r_rs1;
   logic [31:0] r_rs2;
   logic        r_trap;
   logic [3:0]  r_cause;

   logic        load_en;
   assign load_en = !fw_stall_ex && !fw_stall_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_insn   <= '0;
         r_use_rd <= 1'b0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_trap   <= 1'b0;
         r_cause  <= '0;
      end else begin
         if (load_en) begin
            r_valid  <= d_valid;
            r_pc     <= d_pc;
            r_insn   <= d_insn;
            r_use_rd <= d_use_rd;
            r_rs1    <= d_rs1_val;
            r_rs2    <= d_rs2_val;
            r_trap   <= d_trap;
            r_cause  <= d_cause;
         end
         // A flush wins over a simultaneous load: nothing survives it.
         if (clear) begin
            r_valid <= 1'b0;
            r_trap  <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic [31:0] pc_full;
   logic        is_mdu;
   logic        mdu_go;

   assign opcode  = r_insn[6:0];
   assign funct3  = r_insn[14:12];
   assign funct7  = r_insn[31:25];
   assign imm_i   = {{20{r_insn[31]}}, r_insn[31:20]};
   assign imm_s   = {{20{r_insn[31]}}, r_insn[31:25], r_insn[11:7]};
   assign imm_u   = {r_insn[31:12], 12'h000};
   assign pc_full = {r_pc, 1'b0};
   assign is_mdu  = (opcode == OPC_OP) && (funct7 == 7'b0000001);
   // Trapped or invalid instructions are never treated as MDU work.
   assign mdu_go  = r_valid && !r_trap && is_mdu;

   // ------------------------------------------------------------------
   // ALU and result select
   // ------------------------------------------------------------------
   logic [31:0] alu_b;
   logic [4:0]  shamt;
   logic        alt;
   logic [31:0] sra_res;
   logic [31:0] alu_res;
   logic [31:0] ex_res;

   assign alu_b   = (opcode == OPC_OP) ? r_rs2 : imm_i;
   assign shamt   = alu_b[4:0];
   assign alt     = r_insn[30];
   assign sra_res = $signed(r_rs1) >>> shamt;

   always_comb begin
      alu_res = '0;
      case (funct3)
         3'd0: alu_res = ((opcode == OPC_OP) && alt) ? (r_rs1 - alu_b)
                                                     : (r_rs1 + alu_b);
         3'd1: alu_res = r_rs1 << shamt;
         3'd2: alu_res = {31'b0, $signed(r_rs1) < $signed(alu_b)};
         3'd3: alu_res = {31'b0, r_rs1 < alu_b};
         3'd4: alu_res = r_rs1 ^ alu_b;
         3'd5: alu_res = alt ? sra_res : (r_rs1 >> shamt);
         3'd6: alu_res = r_rs1 | alu_b;
         3'd7: alu_res = r_rs1 & alu_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      ex_res = r_rs1;
      case (opcode)
         OPC_OP, OPC_OP_IMM: ex_res = alu_res;
         OPC_LUI:            ex_res = imm_u;
         OPC_AUIPC:          ex_res = pc_full + imm_u;
         OPC_JAL, OPC_JALR:  ex_res = pc_full + 32'd4;
         OPC_LOAD:           ex_res = r_rs1 + imm_i;
         OPC_STORE:          ex_res = r_rs1 + imm_s;
         default:            ex_res = r_rs1;
      endcase
   end

   logic        mdu_done;
   logic        mdu_illegal;
   logic [31:0] result;

`ifdef BOA_EX_MDU_EN
   // ------------------------------------------------------------------
   // Iterative MDU: 32 shift-add or restoring-divide steps on magnitudes,
   // sign fix-up folded into the last step.
   // ------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  mdu_state;
   logic [4:0]  mdu_cnt;
   logic [2:0]  mdu_f3;
   logic [31:0] mdu_hi;      // product high / partial remainder
   logic [31:0] mdu_lo;      // multiplier / quotient shift register
   logic [31:0] mdu_opnd;    // multiplicand / divisor magnitude
   logic        mdu_neg;     // negate the final result
   logic        mdu_dz;      // divisor was zero
   logic [31:0] mdu_dvd;     // original dividend, returned by REM on /0
   logic [31:0] mdu_res;

   // Operand preparation for the start edge
   logic        a_signed;
   logic        b_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        start_neg;

   assign a_signed  = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                      (funct3 == 3'd4) || (funct3 == 3'd6);
   assign b_signed  = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
   assign a_neg     = a_signed && r_rs1[31];
   assign b_neg     = b_signed && r_rs2[31];
   assign a_mag     = a_neg ? (32'd0 - r_rs1) : r_rs1;
   assign b_mag     = b_neg ? (32'd0 - r_rs2) : r_rs2;
   // REM takes the dividend's sign; MUL*/DIV take the product of signs.
   assign start_neg = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

   // One iteration step
   logic [32:0] mul_sum;
   logic [32:0] div_trial;
   logic        div_ge;
   logic [31:0] next_hi;
   logic [31:0] next_lo;

   assign mul_sum   = {1'b0, mdu_hi} + (mdu_lo[0] ? {1'b0, mdu_opnd} : 33'd0);
   assign div_trial = {mdu_hi, mdu_lo[31]};
   assign div_ge    = div_trial >= {1'b0, mdu_opnd};

   always_comb begin
      if (mdu_f3[2]) begin
         // Partial remainder < divisor, so the difference fits 32 bits.
         next_hi = div_ge ? (div_trial[31:0] - mdu_opnd) : div_trial[31:0];
         next_lo = {mdu_lo[30:0], div_ge};
      end else begin
         next_hi = mul_sum[32:1];
         next_lo = {mul_sum[0], mdu_lo[31:1]};
      end
   end

   // Final-step result with sign fix-up and divide-by-zero override
   logic [63:0] prod;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_res;

   assign prod     = {next_hi, next_lo};
   assign prod_fix = mdu_neg ? (64'd0 - prod) : prod;
   assign quo_fix  = mdu_neg ? (32'd0 - next_lo) : next_lo;
   assign rem_fix  = mdu_neg ? (32'd0 - next_hi) : next_hi;

   always_comb begin
      final_res = '0;
      case (mdu_f3)
         3'd0:             final_res = prod_fix[31:0];
         3'd1, 3'd2, 3'd3: final_res = prod_fix[63:32];
         3'd4, 3'd5:       final_res = mdu_dz ? '1 : quo_fix;
         3'd6, 3'd7:       final_res = mdu_dz ? mdu_dvd : rem_fix;
         default:          final_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdu_state <= ST_IDLE;
         mdu_cnt   <= '0;
         mdu_f3    <= '0;
         mdu_hi    <= '0;
         mdu_lo    <= '0;
         mdu_opnd  <= '0;
         mdu_neg   <= 1'b0;
         mdu_dz    <= 1'b0;
         mdu_dvd   <= '0;
         mdu_res   <= '0;
      end else if (clear) begin
         mdu_state <= ST_IDLE;
      end else begin
         case (mdu_state)
            ST_IDLE: begin
               if (mdu_go) begin
                  mdu_state <= ST_BUSY;
                  mdu_cnt   <= 5'd31;
                  mdu_f3    <= funct3;
                  mdu_hi    <= '0;
                  mdu_lo    <= funct3[2] ? a_mag : b_mag;
                  mdu_opnd  <= funct3[2] ? b_mag : a_mag;
                  mdu_neg   <= start_neg;
                  mdu_dz    <= (r_rs2 == 32'd0);
                  mdu_dvd   <= r_rs1;
               end
            end
            ST_BUSY: begin
               mdu_hi  <= next_hi;
               mdu_lo  <= next_lo;
               mdu_cnt <= mdu_cnt - 5'd1;
               if (mdu_cnt == 5'd0) begin
                  mdu_res   <= final_res;
                  mdu_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!fw_stall_ex) mdu_state <= ST_IDLE;
            end
            default: mdu_state <= ST_IDLE;
         endcase
      end
   end

   assign fw_stall_out = ((mdu_state == ST_IDLE) && mdu_go) || (mdu_state == ST_BUSY);
   assign mdu_done     = (mdu_state == ST_DONE);
   assign mdu_illegal  = 1'b0;
   assign result       = mdu_done ? mdu_res : ex_res;
`else
   assign fw_stall_out = 1'b0;
   assign mdu_done     = 1'b0;
   assign mdu_illegal  = mdu_go;
   assign result       = ex_res;
`endif

   // ------------------------------------------------------------------
   // EX/MEM outputs
   // ------------------------------------------------------------------
   assign q_valid   = r_valid && !clear && (!mdu_go || mdu_done);
   assign q_pc      = r_pc;
   assign q_insn    = r_insn;
   assign q_use_rd  = r_use_rd;
   assign q_rs1_val = result;
   assign q_rs2_val = r_rs2;
   assign q_trap    = (r_trap || mdu_illegal) && !clear;
   assign q_cause   = r_trap ? r_cause : (mdu_illegal ? CAUSE_ILLEGAL : r_cause);

endmodule
